stream_tagger: RTL and testbench
================================

// Module: stream_tagger
// PURPOSE
// - Upstream stage of the crossbar: takes one untagged data stream and attaches a destination tag to each element.
// - Broadcasts each element, with its tag, to NUM_OUTPUTS tagged-multiplexer inputs through an eager fork.
// - Each mux accepts elements whose tag equals its ID; it returns ready=1 for elements carrying other tags.
// - Throughput is 1 element/cycle when all outputs are ready. Latency is 1 cycle through a single output register stage.
// PARAMETERS
// - data_t         (none)  payload type; key bits are taken from the packed payload.
// - TAG_WIDTH      2       width of the tag field.
// - NUM_TAGS       4       number of destinations, 1..2**TAG_WIDTH.
// - NUM_OUTPUTS    4       fork fan-out; one copy per downstream mux.
// - TAG_MODE       0       0 = round-robin, 1 = key low bits, 2 = multiplicative hash.
// - KEY_LSB        0       bit offset of the 32-bit key inside data_t (modes 1 and 2).
// - RR_RESET_LAST  1       1 = round-robin counter returns to 0 after a last element.
// PORTS
// - clk             in   1                  clock
// - rst_n           in   1                  synchronous reset, active-low
// - in.data         in   $bits(data_t)      payload
// - in.keep         in   1                  element carries valid payload
// - in.last         in   1                  end of stream
// - in.valid        in   1                  input handshake
// - in.ready        out  1                  input handshake
// - out[j].data     out  $bits(data_t)      payload copy j, for j < NUM_OUTPUTS
// - out[j].keep     out  1                  keep copy j
// - out[j].last     out  1                  last copy j
// - out[j].tag      out  TAG_WIDTH          destination tag
// - out[j].valid    out  1                  copy j is pending
// - out[j].ready    in   1                  downstream mux j accepts copy j
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - full=0, done[*]=0, rr_cnt=0.
//   - All out[j].valid=0. in.ready=1 in the first cycle after reset.
//   - Reset mid-transfer drops the held element; it is never re-emitted.
// - Output register: holds data, keep, last, tag and full; the same values drive every out[j].
// - Fork: out[j].valid = full & ~done[j].
//   - done[j] sets when out[j].valid & out[j].ready.
//   - No copy is ever presented twice for the same element.
// - Retire: retire = full & AND_j(done[j] | (out[j].valid & out[j].ready)).
// - Input acceptance: in.ready = ~full | retire. This is combinational from out[*].ready, with no bubble.
// - Load: on in.valid & in.ready the register captures the payload and the computed tag, full=1, done[*]=0.
//   - Retire without load: full=0.
// - Tag computation, done at load time from the input:
//   - Mode 0: tag = rr_cnt.
//   - Mode 1: tag = key[TAG_WIDTH-1:0].
//   - Mode 2: tag = (key * 32'h9E3779B1)[31 -: TAG_WIDTH], using the low 32 bits of the product.
//   - key = data[KEY_LSB +: 32], zero-extended if the payload is shorter.
//   - Modes 1 and 2 require NUM_TAGS == 2**TAG_WIDTH; this is checked by an elaboration assertion.
// - rr_cnt update:
//   - Advances on load with keep=1: next = (rr_cnt == NUM_TAGS-1) ? 0 : rr_cnt+1.
//   - keep=0 elements get tag = rr_cnt and leave the counter unchanged.
//   - Load with last=1 and RR_RESET_LAST=1: rr_cnt <= 0. This takes priority over the advance.
// - last and keep pass through unmodified. Dummy last elements (keep=0, last=1) are forwarded on all copies like any other element.
// - Simultaneous retire and load in one cycle is legal and is the steady state; done[*] is cleared, not set, that cycle.
// - out[j].ready while out[j].valid=0 has no effect.
// - Stalled-output stability: data, keep, last and tag stay constant while full=1 until retire.
// TESTING
// - Round-robin: TAG_MODE=0, NUM_TAGS=3, 7 keep=1 elements, all ready -> tags 0,1,2,0,1,2,0, one element per cycle.
// - Round-robin reset on last: element 2 has last=1 -> tags 0,1,2,0,... ; keep=0 element between -> reuses the current tag, counter holds.
// - Fork stall: NUM_OUTPUTS=2, out[1].ready=0 for 3 cycles, out[0].ready=1
//   -> out[0].valid is high for exactly 1 cycle; in.ready=0 until out[1] accepts, then the element retires.
// - Key mode: TAG_MODE=1, TAG_WIDTH=2, key=32'h5 -> tag 1; key=32'hFF -> tag 3.
// - Hash mode: TAG_MODE=2, TAG_WIDTH=2, key=0 -> tag 0; key=1 -> tag 2'b10.
// - Reset mid-stall: full=1 with out[1] pending, rst_n=0 for one cycle -> all out[j].valid=0, rr_cnt=0, no replay of the element.

Source files
------------

// File: rtl/stream_tagger.sv
// Stream tagger: attaches a destination tag to each input element and forks it to
// NUM_OUTPUTS tagged-mux inputs through a single output register stage.

module stream_tagger_cfg_chk #(
  parameter int TAG_WIDTH = 2,
  parameter int NUM_TAGS  = 4,
  parameter int TAG_MODE  = 0
) ();
  if ((NUM_TAGS < 1) || (NUM_TAGS > (1 << TAG_WIDTH))) begin : g_tags_range
    $error("stream_tagger: NUM_TAGS out of range for TAG_WIDTH");
  end
  if ((TAG_MODE != 0) && (NUM_TAGS != (1 << TAG_WIDTH))) begin : g_tags_full
    $error("stream_tagger: key/hash modes require NUM_TAGS == 2**TAG_WIDTH");
  end
endmodule

module stream_tagger #(
  parameter type data_t        = logic [31:0],
  parameter int  TAG_WIDTH     = 2,
  parameter int  NUM_TAGS      = 4,
  parameter int  NUM_OUTPUTS   = 4,
  parameter int  TAG_MODE      = 0,
  parameter int  KEY_LSB       = 0,
  parameter int  RR_RESET_LAST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  data_t                  in_data_i,
  input  logic                   in_keep_i,
  input  logic                   in_last_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output data_t                  out_data_o [NUM_OUTPUTS],
  output logic [NUM_OUTPUTS-1:0] out_keep_o,
  output logic [NUM_OUTPUTS-1:0] out_last_o,
  output logic [TAG_WIDTH-1:0]   out_tag_o  [NUM_OUTPUTS],
  output logic [NUM_OUTPUTS-1:0] out_valid_o,
  input  logic [NUM_OUTPUTS-1:0] out_ready_i
);

  localparam int DW = $bits(data_t);

  stream_tagger_cfg_chk #(
    .TAG_WIDTH (TAG_WIDTH),
    .NUM_TAGS  (NUM_TAGS),
    .TAG_MODE  (TAG_MODE)
  ) u_cfg_chk ();

  logic                   full_q, full_d;
  logic [NUM_OUTPUTS-1:0] done_q, done_d;
  data_t                  data_q, data_d;
  logic                   keep_q, keep_d;
  logic                   last_q, last_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [TAG_WIDTH-1:0]   rr_cnt_q, rr_cnt_d;

  logic [NUM_OUTPUTS-1:0] accept_s;
  logic                   retire_s;
  logic                   load_s;
  logic [DW+31:0]         data_ext_s;
  logic [31:0]            key_s;
  logic [31:0]            hash_s;
  logic [TAG_WIDTH-1:0]   tag_s;

  // Key is zero-extended when the payload is narrower than KEY_LSB+32 bits.
  assign data_ext_s = {32'd0, in_data_i};
  assign key_s      = 32'(data_ext_s >> KEY_LSB);
  assign hash_s     = key_s * 32'h9E37_79B1;

  assign out_valid_o = {NUM_OUTPUTS{full_q}} & ~done_q;
  assign accept_s    = out_valid_o & out_ready_i;
  assign retire_s    = full_q & (&(done_q | accept_s));
  assign in_ready_o  = ~full_q | retire_s;
  assign load_s      = in_valid_i & in_ready_o;

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
    assign out_data_o[j] = data_q;
    assign out_keep_o[j] = keep_q;
    assign out_last_o[j] = last_q;
    assign out_tag_o[j]  = tag_q;
  end

  // Tag selection for the element being loaded.
  always_comb begin
    case (TAG_MODE)
      1:       tag_s = key_s[TAG_WIDTH-1:0];
      2:       tag_s = TAG_WIDTH'(hash_s >> (32 - TAG_WIDTH));
      default: tag_s = rr_cnt_q;
    endcase
  end

  // Next state of the output register, fork bookkeeping and round-robin counter.
  always_comb begin
    full_d   = full_q;
    done_d   = done_q | accept_s;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    tag_d    = tag_q;
    rr_cnt_d = rr_cnt_q;
    if (load_s) begin
      full_d = 1'b1;
      done_d = {NUM_OUTPUTS{1'b0}};
      data_d = in_data_i;
      keep_d = in_keep_i;
      last_d = in_last_i;
      tag_d  = tag_s;
      if (in_last_i && (RR_RESET_LAST != 0)) begin
        rr_cnt_d = {TAG_WIDTH{1'b0}};
      end else if (in_keep_i) begin
        rr_cnt_d = (rr_cnt_q == TAG_WIDTH'(NUM_TAGS - 1)) ? {TAG_WIDTH{1'b0}}
                                                          : rr_cnt_q + TAG_WIDTH'(1);
      end else begin
        rr_cnt_d = rr_cnt_q;
      end
    end else if (retire_s) begin
      full_d = 1'b0;
      done_d = {NUM_OUTPUTS{1'b0}};
    end else begin
      full_d = full_q;
    end
  end

  // State registers; a held element is discarded on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      done_q   <= {NUM_OUTPUTS{1'b0}};
      data_q   <= data_t'(0);
      keep_q   <= 1'b0;
      last_q   <= 1'b0;
      tag_q    <= {TAG_WIDTH{1'b0}};
      rr_cnt_q <= {TAG_WIDTH{1'b0}};
    end else begin
      full_q   <= full_d;
      done_q   <= done_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      tag_q    <= tag_d;
      rr_cnt_q <= rr_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_tagger.sv
// Scoreboard bench for stream_tagger: round-robin/fork instance plus key and hash instances.
module tb_stream_tagger;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  t;
    logic        k;
    logic        l;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Round-robin instance (NUM_TAGS=3, two outputs)
  logic [31:0] rr_idata = 32'd0;
  logic        rr_ikeep = 1'b0, rr_ilast = 1'b0, rr_ivalid = 1'b0, rr_iready;
  logic [31:0] rr_odata [2];
  logic [1:0]  rr_otag  [2];
  logic [1:0]  rr_okeep, rr_olast, rr_ovalid;
  logic [1:0]  rr_ordy = 2'b11;

  // Key-mode instance
  logic [31:0] key_idata = 32'd0;
  logic        key_ikeep = 1'b0, key_ilast = 1'b0, key_ivalid = 1'b0, key_iready;
  logic [31:0] key_odata [1];
  logic [1:0]  key_otag  [1];
  logic [0:0]  key_okeep, key_olast, key_ovalid;
  logic [0:0]  key_ordy = 1'b1;

  // Hash-mode instance
  logic [31:0] hash_idata = 32'd0;
  logic        hash_ikeep = 1'b0, hash_ilast = 1'b0, hash_ivalid = 1'b0, hash_iready;
  logic [31:0] hash_odata [1];
  logic [1:0]  hash_otag  [1];
  logic [0:0]  hash_okeep, hash_olast, hash_ovalid;
  logic [0:0]  hash_ordy = 1'b1;

  stream_tagger #(.data_t(logic [31:0]), .TAG_WIDTH(2), .NUM_TAGS(3), .NUM_OUTPUTS(2),
                  .TAG_MODE(0), .KEY_LSB(0), .RR_RESET_LAST(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(rr_idata), .in_keep_i(rr_ikeep), .in_last_i(rr_ilast),
    .in_valid_i(rr_ivalid), .in_ready_o(rr_iready),
    .out_data_o(rr_odata), .out_keep_o(rr_okeep), .out_last_o(rr_olast),
    .out_tag_o(rr_otag), .out_valid_o(rr_ovalid), .out_ready_i(rr_ordy));

  stream_tagger #(.data_t(logic [31:0]), .TAG_WIDTH(2), .NUM_TAGS(4), .NUM_OUTPUTS(1),
                  .TAG_MODE(1), .KEY_LSB(0), .RR_RESET_LAST(1)) u_key (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(key_idata), .in_keep_i(key_ikeep), .in_last_i(key_ilast),
    .in_valid_i(key_ivalid), .in_ready_o(key_iready),
    .out_data_o(key_odata), .out_keep_o(key_okeep), .out_last_o(key_olast),
    .out_tag_o(key_otag), .out_valid_o(key_ovalid), .out_ready_i(key_ordy));

  stream_tagger #(.data_t(logic [31:0]), .TAG_WIDTH(2), .NUM_TAGS(4), .NUM_OUTPUTS(1),
                  .TAG_MODE(2), .KEY_LSB(0), .RR_RESET_LAST(1)) u_hash (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(hash_idata), .in_keep_i(hash_ikeep), .in_last_i(hash_ilast),
    .in_valid_i(hash_ivalid), .in_ready_o(hash_iready),
    .out_data_o(hash_odata), .out_keep_o(hash_okeep), .out_last_o(hash_olast),
    .out_tag_o(hash_otag), .out_valid_o(hash_ovalid), .out_ready_i(hash_ordy));

  item_t q_rr0[$], q_rr1[$], q_key[$], q_hash[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_cmp(input string nm, input bit empty, input item_t e, input item_t a);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s: unexpected output actual=%h expected=none", nm, a);
    end else if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (data,tag,keep,last)", nm, a, e);
    end
  endtask

  // Monitor: every accepted copy is popped from its queue and compared.
  item_t m_e, m_a;
  bit    m_emp;
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rr_ovalid[j] && rr_ordy[j]) begin
        m_a = '{rr_odata[j], rr_otag[j], rr_okeep[j], rr_olast[j]};
        m_e = '0;
        if (j == 0) begin
          m_emp = (q_rr0.size() == 0);
          if (!m_emp) m_e = q_rr0.pop_front();
          sb_cmp("rr_out0", m_emp, m_e, m_a);
        end else begin
          m_emp = (q_rr1.size() == 0);
          if (!m_emp) m_e = q_rr1.pop_front();
          sb_cmp("rr_out1", m_emp, m_e, m_a);
        end
      end
    end
    if (key_ovalid[0] && key_ordy[0]) begin
      m_a = '{key_odata[0], key_otag[0], key_okeep[0], key_olast[0]};
      m_e = '0;
      m_emp = (q_key.size() == 0);
      if (!m_emp) m_e = q_key.pop_front();
      sb_cmp("key_out", m_emp, m_e, m_a);
    end
    if (hash_ovalid[0] && hash_ordy[0]) begin
      m_a = '{hash_odata[0], hash_otag[0], hash_okeep[0], hash_olast[0]};
      m_e = '0;
      m_emp = (q_hash.size() == 0);
      if (!m_emp) m_e = q_hash.pop_front();
      sb_cmp("hash_out", m_emp, m_e, m_a);
    end
  end

  // inst: 0 = round-robin, 1 = key, 2 = hash. Returns cycles taken to hand over.
  task automatic send(input int inst, input logic [31:0] d, input logic k, input logic l,
                      input logic [1:0] t, output int cyc);
    item_t it;
    bit    hs;
    it = '{d, t, k, l};
    case (inst)
      0: begin
        rr_idata = d; rr_ikeep = k; rr_ilast = l; rr_ivalid = 1'b1;
        q_rr0.push_back(it); q_rr1.push_back(it);
      end
      1: begin
        key_idata = d; key_ikeep = k; key_ilast = l; key_ivalid = 1'b1;
        q_key.push_back(it);
      end
      default: begin
        hash_idata = d; hash_ikeep = k; hash_ilast = l; hash_ivalid = 1'b1;
        q_hash.push_back(it);
      end
    endcase
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      hs = (inst == 0) ? rr_iready : (inst == 1) ? key_iready : hash_iready;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL send_timeout: inst=%0d data=%0h actual=not accepted required=accepted", inst, d);
    end
    rr_ivalid = 1'b0; key_ivalid = 1'b0; hash_ivalid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        l;
    logic [1:0]  t;
  } vec_t;

  initial begin
    int   cyc, total, vcnt;
    vec_t v2 [10];
    logic [31:0] kd [5];
    logic [1:0]  kt [5];

    // Reset state
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    check("reset_rr_valid",   64'(rr_ovalid),   64'd0);
    check("reset_key_valid",  64'(key_ovalid),  64'd0);
    check("reset_hash_valid", 64'(hash_ovalid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rr_ready", 64'(rr_iready), 64'd1);
    @(posedge clk); #1;

    // Round-robin over 3 tags, back to back
    total = 0;
    for (int i = 0; i < 7; i++) begin
      send(0, 32'h100 + 32'(i), 1'b1, 1'b0, 2'(i % 3), cyc);
      total += cyc;
    end
    check("rr_throughput_cycles", 64'(total), 64'd7);
    tick(3);

    // Round-robin reset on last, keep=0 holding the counter
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    v2[0] = '{32'h200, 1'b1, 1'b0, 2'd0};
    v2[1] = '{32'h201, 1'b1, 1'b0, 2'd1};
    v2[2] = '{32'h202, 1'b1, 1'b1, 2'd2};
    v2[3] = '{32'h203, 1'b1, 1'b0, 2'd0};
    v2[4] = '{32'h204, 1'b0, 1'b0, 2'd1};
    v2[5] = '{32'h205, 1'b1, 1'b0, 2'd1};
    v2[6] = '{32'h206, 1'b1, 1'b0, 2'd2};
    v2[7] = '{32'h207, 1'b1, 1'b0, 2'd0};
    v2[8] = '{32'h208, 1'b0, 1'b1, 2'd1};
    v2[9] = '{32'h209, 1'b1, 1'b0, 2'd0};
    for (int i = 0; i < 10; i++) send(0, v2[i].d, v2[i].k, v2[i].l, v2[i].t, cyc);
    tick(3);

    // Fork stall: out1 not ready for 3 cycles
    rr_ordy = 2'b01;
    send(0, 32'h2A0, 1'b1, 1'b0, 2'd1, cyc);
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rr_ovalid[0]) vcnt++;
      check("stall_in_ready_low", 64'(rr_iready), 64'd0);
      check("stall_out1_valid",   64'(rr_ovalid[1]), 64'd1);
      @(posedge clk); #1;
    end
    check("stall_out0_valid_cycles", 64'(vcnt), 64'd1);
    rr_ordy = 2'b11;
    @(negedge clk);
    check("stall_release_in_ready", 64'(rr_iready), 64'd1);
    check("stall_release_valid",    64'(rr_ovalid), 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_retired_valid", 64'(rr_ovalid), 64'd0);
    @(posedge clk); #1;

    // Key mode
    kd[0] = 32'h5; kd[1] = 32'hFF; kd[2] = 32'h6; kd[3] = 32'h0; kd[4] = 32'hFFFF_FFFC;
    kt[0] = 2'd1;  kt[1] = 2'd3;   kt[2] = 2'd2;  kt[3] = 2'd0;  kt[4] = 2'd0;
    for (int i = 0; i < 5; i++) send(1, kd[i], 1'b1, (i == 4) ? 1'b1 : 1'b0, kt[i], cyc);

    // Hash mode: top 2 bits of key*0x9E3779B1
    kd[0] = 32'h0; kd[1] = 32'h1; kd[2] = 32'h2; kd[3] = 32'h3;
    kt[0] = 2'd0;  kt[1] = 2'd2;  kt[2] = 2'd0;  kt[3] = 2'd3;
    for (int i = 0; i < 4; i++) send(2, kd[i], 1'b1, 1'b0, kt[i], cyc);
    tick(3);

    // Reset mid-stall: element held with out1 pending, then dropped
    rr_ordy = 2'b01;
    send(0, 32'h2B0, 1'b0, 1'b0, 2'd2, cyc);
    tick(1);
    rst_n = 1'b0;
    q_rr1.delete();
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_valid", 64'(rr_ovalid), 64'd0);
    check("midreset_ready", 64'(rr_iready), 64'd1);
    @(posedge clk); #1;
    rr_ordy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_no_replay", 64'(rr_ovalid), 64'd0);
      @(posedge clk); #1;
    end
    send(0, 32'h300, 1'b1, 1'b0, 2'd0, cyc);
    tick(3);

    check("sb_drain_rr0",  64'(q_rr0.size()),  64'd0);
    check("sb_drain_rr1",  64'(q_rr1.size()),  64'd0);
    check("sb_drain_key",  64'(q_key.size()),  64'd0);
    check("sb_drain_hash", 64'(q_hash.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
